dcmi_tx: RTL and testbench

DCMI_TX -- requirements
Module: dcmi_tx

---
 rtl/dcmi_pkg.sv | 17 +
 rtl/dcmi_tx_unpack.sv | 40 ++++
 rtl/dcmi_tx.sv | 150 +++++++++++++++
 tb/tb_dcmi_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dcmi_pkg.sv
// Shared constants and the state encoding for the DCMI byte-stream transmitter.
package dcmi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VFP    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBL    = 3'd3,
    ST_VBP    = 3'd4
  } state_t;

  localparam int BYTE_LANES = 4;
  localparam int LANE_W     = 2;
  localparam int CNT_W      = 16;
  localparam int WORD_CNT_W = 32;

endpackage

// File: rtl/dcmi_tx_unpack.sv
// One-word holding register that hands out its bytes LSB first.
module dcmi_tx_unpack
  import dcmi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        consume,
  output logic        valid,
  output logic        last,
  output logic [7:0]  byte_sel
);

  logic [31:0]       word;
  logic [31:0]       shifted;
  logic [LANE_W-1:0] lane;

  assign last     = valid && (lane == LANE_W'(BYTE_LANES - 1));
  assign shifted  = word >> {lane, 3'b000};
  assign byte_sel = shifted[7:0];

  // A load may coincide with consuming the final byte; the new word wins.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      word  <= '0;
      lane  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_data;
      lane  <= '0;
    end else if (consume && valid) begin
      if (last) valid <= 1'b0;
      lane <= lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/dcmi_tx.sv
// DCMI-style transmitter: frames a stream of 32-bit words into vsync/hsync/de byte timing.
//   state  | meaning
//   IDLE   | waiting for start
//   VFP    | VBLANK cycles before the first line, first word prefetched
//   ACTIVE | emitting line bytes, stalls while the holding register is empty
//   HBL    | HBLANK idle cycles between lines, next word prefetched
//   VBP    | VBLANK cycles after the last line, frame_done in its final cycle
module dcmi_tx
  import dcmi_pkg::*;
#(
  parameter int LINE_BYTES  = 640,
  parameter int FRAME_LINES = 480,
  parameter int HBLANK      = 16,
  parameter int VBLANK      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        block_en,
  input  logic        start,
  input  logic        src_rdy,
  output logic        src_req,
  input  logic [31:0] src_data,
  output logic        dcmi_vsync,
  output logic        dcmi_hsync,
  output logic        dcmi_de,
  output logic [7:0]  dcmi_data,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(FRAME_LINES - 1);
  localparam logic [CNT_W-1:0] HBL_LAST  = CNT_W'(HBLANK - 1);
  localparam logic [CNT_W-1:0] VBL_LAST  = CNT_W'(VBLANK - 1);
  localparam logic [WORD_CNT_W-1:0] FRAME_WORDS =
    WORD_CNT_W'((LINE_BYTES / BYTE_LANES) * FRAME_LINES);

  state_t                state;
  logic [CNT_W-1:0]      byte_cnt;
  logic [CNT_W-1:0]      line_cnt;
  logic [CNT_W-1:0]      blank_cnt;
  logic [WORD_CNT_W-1:0] words_left;

  logic       hold_valid;
  logic       hold_last;
  logic [7:0] hold_byte;
  logic       emit;
  logic       xfer;

  assign emit = (state == ST_ACTIVE) && hold_valid;

  // Decoded only from flops so a pop completes in the same cycle it is offered.
  assign src_req = (state != ST_IDLE) && (words_left != '0) &&
                   (!hold_valid || (emit && hold_last));
  assign xfer    = src_req && src_rdy;

  dcmi_tx_unpack u_unpack (
    .clk       (clk),
    .rst       (rst),
    .clear     (!block_en),
    .load      (xfer),
    .load_data (src_data),
    .consume   (emit),
    .valid     (hold_valid),
    .last      (hold_last),
    .byte_sel  (hold_byte)
  );

  always_ff @(posedge clk) begin
    if (rst || !block_en) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      blank_cnt  <= '0;
      words_left <= '0;
      dcmi_vsync <= 1'b0;
      dcmi_hsync <= 1'b0;
      dcmi_de    <= 1'b0;
      dcmi_data  <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dcmi_vsync <= (state != ST_IDLE);
      busy       <= (state != ST_IDLE);
      dcmi_hsync <= (state == ST_ACTIVE);
      dcmi_de    <= emit;
      dcmi_data  <= emit ? hold_byte : 8'h00;
      frame_done <= 1'b0;
      if (xfer) words_left <= words_left - WORD_CNT_W'(1);

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_VFP;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            blank_cnt  <= '0;
            words_left <= FRAME_WORDS;
            underrun   <= 1'b0;
          end
        end
        ST_VFP: begin
          if (blank_cnt == VBL_LAST) begin
            state     <= ST_ACTIVE;
            blank_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          // Starved: hsync stays up, counters freeze until a word arrives.
          if (!hold_valid) begin
            underrun <= 1'b1;
          end else if (byte_cnt == BYTE_LAST) begin
            byte_cnt <= '0;
            if (line_cnt == LINE_LAST) begin
              state <= ST_VBP;
            end else begin
              line_cnt <= line_cnt + CNT_W'(1);
              state    <= ST_HBL;
            end
          end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
          end
        end
        ST_HBL: begin
          if (blank_cnt == HBL_LAST) begin
            state     <= ST_ACTIVE;
            blank_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
        ST_VBP: begin
          if (blank_cnt == VBL_LAST) begin
            state      <= ST_IDLE;
            blank_cnt  <= '0;
            frame_done <= 1'b1;
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcmi_tx.sv
// Bench for dcmi_tx: two instances (two-line and one-line frames) driven through a shared source.
module tb_dcmi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, block_en, start, src_rdy, sel;
  logic [31:0] src_data;
  logic        start0, start1;

  assign start0 = start && !sel;
  assign start1 = start && sel;

  logic       req0, vs0, hs0, de0, busy0, fd0, unr0;
  logic [7:0] d0;
  logic       req1, vs1, hs1, de1, busy1, fd1, unr1;
  logic [7:0] d1;

  dcmi_tx #(.LINE_BYTES(8), .FRAME_LINES(2), .HBLANK(2), .VBLANK(3)) u_dut (
    .clk(clk), .rst(rst), .block_en(block_en), .start(start0), .src_rdy(src_rdy),
    .src_req(req0), .src_data(src_data), .dcmi_vsync(vs0), .dcmi_hsync(hs0),
    .dcmi_de(de0), .dcmi_data(d0), .busy(busy0), .frame_done(fd0), .underrun(unr0)
  );

  dcmi_tx #(.LINE_BYTES(8), .FRAME_LINES(1), .HBLANK(1), .VBLANK(3)) u_dut_one (
    .clk(clk), .rst(rst), .block_en(block_en), .start(start1), .src_rdy(src_rdy),
    .src_req(req1), .src_data(src_data), .dcmi_vsync(vs1), .dcmi_hsync(hs1),
    .dcmi_de(de1), .dcmi_data(d1), .busy(busy1), .frame_done(fd1), .underrun(unr1)
  );

  logic       req, vs, hs, de, busy, fd, unr;
  logic [7:0] data;
  assign {req, vs, hs, de, busy, fd, unr, data} =
    sel ? {req1, vs1, hs1, de1, busy1, fd1, unr1, d1}
        : {req0, vs0, hs0, de0, busy0, fd0, unr0, d0};

  int checks = 0;
  int errors = 0;

  // Frame geometry of the instance currently observed.
  int lb, fl, hb, vb;

  logic [31:0] words[$];
  int          widx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_words(input bit directed);
    int n;
    words.delete();
    n = (lb / 4) * fl;
    for (int k = 0; k < n; k++)
      words.push_back(directed ? (32'h03020100 + 32'(k) * 32'h04040404) : $urandom);
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 drop for 5 cycles at the second pop of line 0.
  // abort_kind: 0 none, 1 block_en low during line 1, 2 rst during VFP.
  task automatic run_frame(input string name, input int rdy_mode, input bit hold_start,
                           input int abort_kind, input bit directed);
    int e, vs_cnt, hs_cnt, hs_pulses, de_in_pulse, bad_line, bad_out, gap_cnt;
    int fd_cnt, fd_at, pops, pre_hs, drop_left, post, abort_e, nwords;
    bit xfer, dropped, aborted, prev_hs, first_vs, done;
    logic [7:0] got[$];
    logic [7:0] exp_b;

    fill_words(directed);
    nwords = words.size();
    widx = 0;
    e = -1; vs_cnt = 0; hs_cnt = 0; hs_pulses = 0; de_in_pulse = 0; bad_line = 0;
    bad_out = 0; gap_cnt = 0; fd_cnt = 0; fd_at = -1; pops = 0; pre_hs = 0;
    drop_left = 0; post = 0; abort_e = 0;
    dropped = 0; aborted = 0; prev_hs = 0; first_vs = 0; done = 0;

    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      case (rdy_mode)
        0:       src_rdy = 1'b1;
        1:       src_rdy = ($urandom_range(0, 3) != 0);
        default: src_rdy = (drop_left == 0);
      endcase
      if (aborted) src_rdy = 1'b0;
      src_data = (widx < nwords) ? words[widx] : $urandom;
      xfer = req && src_rdy;

      @(posedge clk);
      e++;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (xfer) begin
        widx++;
        pops++;
      end
      if (drop_left > 0) drop_left--;

      if (vs) begin
        vs_cnt++;
        if (!first_vs) begin
          first_vs = 1;
          chk({name, "_unr_clear"}, 32'(unr), 32'd0);
        end
      end
      if (vs && !hs && hs_pulses == 0) pre_hs++;
      if (hs) begin
        hs_cnt++;
        if (!prev_hs) begin
          hs_pulses++;
          de_in_pulse = 0;
        end
        if (de) de_in_pulse++;
        else gap_cnt++;
      end
      if (prev_hs && !hs && de_in_pulse != lb) bad_line++;
      if ((de && !hs) || (!de && data != 8'h00) || (busy != vs)) bad_out++;
      if (de) got.push_back(data);
      if (fd) begin
        fd_cnt++;
        fd_at = e;
        if (hold_start) start = 1'b0;
      end
      prev_hs = hs;

      if (rdy_mode == 2 && !dropped && de && got.size() == 3) begin
        dropped = 1;
        drop_left = 5;
      end

      if (abort_kind == 1 && !aborted && hs && hs_pulses == 2 && de_in_pulse == 3) begin
        block_en = 1'b0; start = 1'b0; aborted = 1; abort_e = e;
      end
      if (abort_kind == 2 && !aborted && vs) begin
        rst = 1'b1; start = 1'b0; aborted = 1; abort_e = e;
      end
      if (aborted && (e == abort_e + 1 || e == abort_e + 2))
        chk({name, "_abort_zero"}, 32'({req, vs, hs, de, busy, fd, unr, data}), 32'd0);
      if (aborted && e == abort_e + 2) begin
        rst = 1'b0;
        block_en = 1'b1;
      end
      if (aborted && e == abort_e + 6) done = 1;

      if (fd_cnt > 0) post++;
      if (post == 5) done = 1;
    end
    src_rdy = 1'b0;
    start = 1'b0;

    chk({name, "_finished"}, 32'(done), 32'd1);
    if (abort_kind != 0) begin
      chk({name, "_no_fd"}, 32'(fd_cnt), 32'd0);
    end else begin
      chk({name, "_fd_count"}, 32'(fd_cnt), 32'd1);
      chk({name, "_fd_last_vs"}, 32'(fd_at), 32'(vs_cnt));
      chk({name, "_vs_len"}, 32'(vs_cnt), 32'(2 * vb + hb * (fl - 1) + hs_cnt));
      chk({name, "_hs_pulses"}, 32'(hs_pulses), 32'(fl));
      chk({name, "_front_blank"}, 32'(pre_hs), 32'(vb));
      chk({name, "_line_bytes"}, 32'(bad_line), 32'd0);
      chk({name, "_out_rules"}, 32'(bad_out), 32'd0);
      chk({name, "_pops"}, 32'(pops), 32'(nwords));
      chk({name, "_byte_count"}, 32'(got.size()), 32'(lb * fl));
      for (int i = 0; i < got.size() && i < nwords * 4; i++) begin
        exp_b = 8'(words[i / 4] >> (8 * (i % 4)));
        chk({name, "_byte"}, 32'(got[i]), 32'(exp_b));
      end
      chk({name, "_underrun"}, 32'(unr), 32'(gap_cnt != 0));
      if (rdy_mode == 0)
        chk({name, "_fd_at"}, 32'(fd_at), 32'(2 * vb + hb * (fl - 1) + lb * fl));
      if (rdy_mode == 2)
        chk({name, "_gap"}, 32'(gap_cnt), 32'd5);
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; block_en = 1'b1; start = 1'b0; src_rdy = 1'b0; src_data = '0;
    lb = 8; fl = 2; hb = 2; vb = 3;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({req, vs, hs, de, busy, fd, unr, data}), 32'd0);
    chk("reset_outs_one", 32'({req1, vs1, hs1, de1, busy1, fd1, unr1, d1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame("basic", 0, 1'b0, 0, 1'b1);
    run_frame("stall", 2, 1'b0, 0, 1'b1);
    repeat (5) @(negedge clk);
    chk("unr_sticky", 32'(unr), 32'd1);
    run_frame("en_abort", 0, 1'b0, 1, 1'b1);
    run_frame("after_en", 0, 1'b0, 0, 1'b1);
    run_frame("hold_start", 0, 1'b1, 0, 1'b0);
    run_frame("rst_vfp", 0, 1'b0, 2, 1'b1);
    run_frame("after_rst", 0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 6; r++)
      run_frame("rand", 1, 1'($urandom_range(0, 1)), 0, 1'b0);

    @(negedge clk);
    sel = 1'b1;
    lb = 8; fl = 1; hb = 1; vb = 3;
    run_frame("one_line", 0, 1'b0, 0, 1'b1);
    run_frame("one_line_rand", 1, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
